// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with a registered
// carry. A start in IDLE or DONE loads the operands; sum/cout update only on RUN->DONE.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
        // New bit enters at the MSB; after WIDTH steps the first bit sits at the LSB.
        res_next = {fa_sum, res_q};

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d   = res_next[WIDTH-1:1];
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = res_next;
                    cout_d  = fa_carry;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): expected {cout,sum} values are queued
// when an operation is started and compared when done pulses.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic [8:0] exp_q[$];
    int         pass_cnt = 0;
    int         chk_cnt  = 0;

    logic [7:0] b2b_a[3]   = '{8'h12, 8'hC8, 8'hFF};
    logic [7:0] b2b_b[3]   = '{8'h34, 8'h77, 8'hFF};
    logic       b2b_cin[3] = '{1'b0, 1'b1, 1'b1};

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] model_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    task automatic pop_check(input string tag);
        logic [8:0] exp;
        if (exp_q.size() == 0) begin
            chk_cnt++;
            $error("FAIL %s: observed empty scoreboard expected queued result", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {23'd0, cout, sum}, {23'd0, exp});
        end
    endtask

    // Starts one operation at the current negedge and follows it to its done pulse.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input bit scramble, input bit inject, input string tag);
        int k;
        int busy_cnt;
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        exp_q.push_back(model_add(ta, tb_v, tc));
        @(negedge clk);
        start    = 1'b0;
        k        = 0;
        busy_cnt = 0;
        if (scramble) begin
            a   = 8'h00;
            b   = 8'h00;
            cin = 1'b0;
        end
        while (!done && k < 20) begin
            if (busy) busy_cnt++;
            if (inject && k == 3) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
                cin   = 1'b1;
            end
            if (inject && k == 4) start = 1'b0;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 8);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        pop_check({tag, "_result"});
        @(negedge clk);
        check({tag, "_done_width"}, {31'd0, done}, 0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int k;
        int busy_cnt;
        int done_seen;
        logic [8:0] held;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_sum", {24'd0, sum}, 0);
        check("reset_cout", {31'd0, cout}, 0);
        rst_n = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 0, 0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, 0, 0, "wrap");
        run_op(8'h3C, 8'h42, 1'b0, 0, 0, "plain");

        // Result must persist through IDLE.
        held = model_add(8'h3C, 8'h42, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_idle", {23'd0, cout, sum}, {23'd0, held});

        run_op(8'hA5, 8'h5A, 1'b1, 1, 0, "scramble");
        run_op(8'h01, 8'h02, 1'b0, 0, 1, "ignore_start");

        // Start held high: back-to-back operations.
        a     = b2b_a[0];
        b     = b2b_b[0];
        cin   = b2b_cin[0];
        start = 1'b1;
        exp_q.push_back(model_add(b2b_a[0], b2b_b[0], b2b_cin[0]));
        for (int op = 0; op < 3; op++) begin
            @(negedge clk);
            k        = 0;
            busy_cnt = 0;
            while (!done && k < 20) begin
                if (busy) busy_cnt++;
                @(negedge clk);
                k++;
            end
            check("b2b_period", k, 8);
            check("b2b_busy_cycles", busy_cnt, 8);
            check("b2b_busy_at_done", {31'd0, busy}, 0);
            pop_check("b2b_result");
            if (op < 2) begin
                a   = b2b_a[op+1];
                b   = b2b_b[op+1];
                cin = b2b_cin[op+1];
                exp_q.push_back(model_add(b2b_a[op+1], b2b_b[op+1], b2b_cin[op+1]));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_done", {31'd0, done}, 0);
        check("b2b_end_busy", {31'd0, busy}, 0);

        // Asynchronous reset in the middle of RUN.
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_sum", {24'd0, sum}, 0);
        check("abort_cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_sum_held", {23'd0, cout, sum}, 0);

        run_op(8'h80, 8'h80, 1'b1, 0, 0, "after_reset");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
